// File: rtl/mem_io_slave_if.sv
// Bus-side signals of one 8088 memory/IO slave: strobes and address in, READY/SEL/WP_ERR out.
// The bidirectional data bus is a plain inout on the slave so tristate resolution stays at net level.
interface mem_io_slave_if #(
    parameter int ADDR_W = 20
);
    logic              ALE;
    logic              RD;
    logic              WR;
    logic              IOM;
    logic [ADDR_W-1:0] ADDRESS;
    logic              READY;
    logic              SEL;
    logic              WP_ERR;

    modport master (
        output ALE, RD, WR, IOM, ADDRESS,
        input  READY, SEL, WP_ERR
    );

    modport slave (
        input  ALE, RD, WR, IOM, ADDRESS,
        output READY, SEL, WP_ERR
    );
endinterface

// File: rtl/mem_io_slave.sv
// Memory/IO slave for the multiplexed 8088 bus: window decode, programmable wait states,
// optional read-only mode with write-protect error pulse.
module mem_io_slave #(
    parameter int              ADDR_W      = 20,
    parameter int              DEPTH_LOG2  = 10,
    parameter logic [ADDR_W-1:0] BASE      = 20'h00000,
    parameter bit              IS_IO       = 1'b0,
    parameter int              WAIT_STATES = 0,
    parameter bit              READ_ONLY   = 1'b0,
    parameter string           INIT_FILE   = ""
) (
    input  logic               CLK,
    input  logic               RESET,
    mem_io_slave_if.slave      bus,
    inout  wire  [7:0]         Data
);

    if (BASE[DEPTH_LOG2-1:0] != '0) begin : g_base_chk
        $error("mem_io_slave: BASE must be aligned to the window size");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_ws_chk
        $error("mem_io_slave: WAIT_STATES must be within 0..15");
    end

    localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, DONE} state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] addr;
    logic                  op_wr;
    logic [3:0]            wcnt;
    logic [7:0]            mem [2**DEPTH_LOG2];

    logic hit;
    logic one_strobe;
    logic drive;

    assign hit = (bus.IOM == IS_IO) &&
                 (bus.ADDRESS[ADDR_W-1:DEPTH_LOG2] == BASE[ADDR_W-1:DEPTH_LOG2]);
    // Exactly one strobe low; both low is a protocol error and is ignored.
    assign one_strobe = bus.RD ^ bus.WR;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            addr  <= '0;
            op_wr <= 1'b0;
            wcnt  <= '0;
        end else if (bus.ALE) begin
            // A new address phase always wins, aborting whatever was in flight.
            wcnt <= '0;
            if (hit) begin
                state <= ADDR;
                addr  <= bus.ADDRESS[DEPTH_LOG2-1:0];
            end else begin
                state <= IDLE;
            end
        end else begin
            case (state)
                ADDR: if (one_strobe) begin
                    op_wr <= ~bus.WR;
                    if (WAIT_STATES == 0) begin
                        state <= DATA;
                    end else begin
                        wcnt  <= WCNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: if (wcnt == 4'd0) state <= DATA;
                      else              wcnt  <= wcnt - 4'd1;
                DATA: state <= DONE;
                DONE: if (bus.RD && bus.WR) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    if (!READ_ONLY) begin : g_wr
        always_ff @(posedge CLK) begin
            if (!RESET && !bus.ALE && state == DATA && op_wr)
                mem[addr] <= Data;
        end
    end

    assign bus.READY  = (state != WAIT);
    assign bus.SEL    = (state != IDLE);
    assign bus.WP_ERR = READ_ONLY && (state == DATA) && op_wr;

    assign drive = ((state == DATA) || (state == DONE)) && !bus.RD && !op_wr;
    assign Data  = drive ? mem[addr] : 8'hzz;

endmodule

// File: tb/tb_mem_io_slave.sv
// Four slaves on one shared bus (RAM WS0, RAM WS3, IO, ROM); directed per-cycle vectors
// with hand-computed READY/SEL/WP_ERR/Data, plus abort and reset sequences.
module tb_mem_io_slave;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        ale, rd_n, wr_n, iom;
    logic [19:0] address;
    logic        tb_oe;
    logic [7:0]  tb_d;
    tri1  [7:0]  data_bus;

    logic [3:0]  ready_v, sel_v, wp_v;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    assign data_bus = tb_oe ? tb_d : 8'hzz;

    mem_io_slave_if #(.ADDR_W(20)) bif[4] ();

    for (genvar i = 0; i < 4; i++) begin : g_bus
        assign bif[i].ALE     = ale;
        assign bif[i].RD      = rd_n;
        assign bif[i].WR      = wr_n;
        assign bif[i].IOM     = iom;
        assign bif[i].ADDRESS = address;
        assign ready_v[i]     = bif[i].READY;
        assign sel_v[i]       = bif[i].SEL;
        assign wp_v[i]        = bif[i].WP_ERR;
    end

    mem_io_slave #(.BASE(20'h00400), .WAIT_STATES(0)) u_ram0 (
        .CLK(CLK), .RESET(RESET), .bus(bif[0]), .Data(data_bus));
    mem_io_slave #(.BASE(20'h01000), .WAIT_STATES(3)) u_ram3 (
        .CLK(CLK), .RESET(RESET), .bus(bif[1]), .Data(data_bus));
    mem_io_slave #(.BASE(20'h00400), .IS_IO(1'b1)) u_io (
        .CLK(CLK), .RESET(RESET), .bus(bif[2]), .Data(data_bus));
    mem_io_slave #(.BASE(20'h02000), .READ_ONLY(1'b1)) u_rom (
        .CLK(CLK), .RESET(RESET), .bus(bif[3]), .Data(data_bus));

    // ROM preload stands in for an init file: offset 5 holds 8'h3C.
    initial u_rom.mem[5] = 8'h3C;

    typedef struct {
        logic        rst, ale, rd, wr, iom;
        logic [19:0] addr;
        logic        oe;
        logic [7:0]  dout;
        logic [3:0]  ready, sel, wp;
        logic        chk;
        logic [7:0]  dat;
    } vec_t;

    vec_t tbl[$];
    int   vidx = 0;

    localparam logic [3:0] RF = 4'b1111;   // all ready
    localparam logic [3:0] RW = 4'b1101;   // WS3 RAM holding READY low

    function automatic vec_t v(logic rst, logic a, logic r, logic w, logic io,
                               logic [19:0] ad, logic oe, logic [7:0] d,
                               logic [3:0] rdy, logic [3:0] s, logic [3:0] wp,
                               logic c, logic [7:0] dat);
        vec_t x;
        x.rst = rst; x.ale = a; x.rd = r; x.wr = w; x.iom = io; x.addr = ad;
        x.oe = oe; x.dout = d; x.ready = rdy; x.sel = s; x.wp = wp; x.chk = c; x.dat = dat;
        return x;
    endfunction

    function automatic void add_wr0(logic [19:0] a, logic io, logic [7:0] d,
                                    logic [3:0] s, logic [3:0] wp);
        tbl.push_back(v(0,1,1,1,io,a,0,8'h00, RF,s,4'h0, 1,8'hFF));
        tbl.push_back(v(0,0,1,0,io,a,1,d,     RF,s,wp,   0,8'h00));
        tbl.push_back(v(0,0,1,0,io,a,1,d,     RF,s,4'h0, 0,8'h00));
        tbl.push_back(v(0,0,1,1,io,a,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));
    endfunction

    function automatic void add_rd0(logic [19:0] a, logic io, logic [7:0] d, logic [3:0] s);
        tbl.push_back(v(0,1,1,1,io,a,0,8'h00, RF,s,4'h0, 1,8'hFF));
        tbl.push_back(v(0,0,0,1,io,a,0,8'h00, RF,s,4'h0, 1,d));
        tbl.push_back(v(0,0,0,1,io,a,0,8'h00, RF,s,4'h0, 1,d));
        tbl.push_back(v(0,0,1,1,io,a,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));
    endfunction

    task automatic cmp(string nm, logic [7:0] act, logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vector %0d): got %h, expected %h", nm, vidx, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, check outputs mid-cycle.
    task automatic step(vec_t x);
        RESET = x.rst; ale = x.ale; rd_n = x.rd; wr_n = x.wr; iom = x.iom;
        address = x.addr; tb_oe = x.oe; tb_d = x.dout;
        @(posedge CLK);
        @(negedge CLK);
        cmp("ready",  {4'h0, ready_v}, {4'h0, x.ready});
        cmp("sel",    {4'h0, sel_v},   {4'h0, x.sel});
        cmp("wp_err", {4'h0, wp_v},    {4'h0, x.wp});
        if (x.chk) cmp("data", data_bus, x.dat);
        vidx++;
    endtask

    initial begin
        RESET = 1'b1; ale = 1'b0; rd_n = 1'b1; wr_n = 1'b1; iom = 1'b0;
        address = '0; tb_oe = 1'b0; tb_d = '0;
        @(negedge CLK);

        // Reset state.
        tbl.push_back(v(1,0,1,1,0,20'h0,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));
        tbl.push_back(v(1,0,1,1,0,20'h0,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));
        // Window hit write/read, then a miss that must not alias onto offset 0x12.
        add_wr0(20'h00412, 1'b0, 8'hA5, 4'b0001, 4'h0);
        add_rd0(20'h00412, 1'b0, 8'hA5, 4'b0001);
        add_wr0(20'h00812, 1'b0, 8'h5A, 4'b0000, 4'h0);
        add_rd0(20'h00412, 1'b0, 8'hA5, 4'b0001);
        // IO instance answers only IO cycles; memory cycle still returns RAM data.
        add_wr0(20'h00412, 1'b1, 8'hC3, 4'b0100, 4'h0);
        add_rd0(20'h00412, 1'b1, 8'hC3, 4'b0100);
        add_rd0(20'h00412, 1'b0, 8'hA5, 4'b0001);
        // Three wait states: write 8'h77 then read it back at 0x1005.
        tbl.push_back(v(0,1,1,1,0,20'h01005,0,8'h00, RF,4'b0010,4'h0, 1,8'hFF));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,0,1,0,0,20'h01005,1,8'h77, RW,4'b0010,4'h0, 0,8'h00));
        tbl.push_back(v(0,0,1,0,0,20'h01005,1,8'h77, RF,4'b0010,4'h0, 0,8'h00));
        tbl.push_back(v(0,0,1,0,0,20'h01005,1,8'h77, RF,4'b0010,4'h0, 0,8'h00));
        tbl.push_back(v(0,0,1,1,0,20'h01005,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));
        tbl.push_back(v(0,1,1,1,0,20'h01005,0,8'h00, RF,4'b0010,4'h0, 1,8'hFF));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,0,0,1,0,20'h01005,0,8'h00, RW,4'b0010,4'h0, 1,8'hFF));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,0,0,1,0,20'h01005,0,8'h00, RF,4'b0010,4'h0, 1,8'h77));
        tbl.push_back(v(0,0,1,1,0,20'h01005,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));
        // Read-only: write flags WP_ERR for one cycle and leaves contents alone.
        add_wr0(20'h02005, 1'b0, 8'hFF, 4'b1000, 4'b1000);
        add_rd0(20'h02005, 1'b0, 8'h3C, 4'b1000);

        foreach (tbl[i]) step(tbl[i]);

        // Abort: ALE during WAIT kills the write; READY is back next cycle.
        step(v(0,1,1,1,0,20'h01005,0,8'h00, RF,4'b0010,4'h0, 1,8'hFF));
        step(v(0,0,1,0,0,20'h01005,1,8'h11, RW,4'b0010,4'h0, 0,8'h00));
        step(v(0,0,1,0,0,20'h01005,1,8'h11, RW,4'b0010,4'h0, 0,8'h00));
        step(v(0,1,1,1,0,20'h01005,0,8'h00, RF,4'b0010,4'h0, 1,8'hFF));
        for (int i = 0; i < 3; i++)
            step(v(0,0,0,1,0,20'h01005,0,8'h00, RW,4'b0010,4'h0, 1,8'hFF));
        step(v(0,0,0,1,0,20'h01005,0,8'h00, RF,4'b0010,4'h0, 1,8'h77));
        step(v(0,0,1,1,0,20'h01005,0,8'h00, RF,4'b0010,4'h0, 1,8'hFF));
        step(v(0,0,1,1,0,20'h01005,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));

        // Reset in DONE of a read: bus released at once, memory kept.
        step(v(0,1,1,1,0,20'h00412,0,8'h00, RF,4'b0001,4'h0, 1,8'hFF));
        step(v(0,0,0,1,0,20'h00412,0,8'h00, RF,4'b0001,4'h0, 1,8'hA5));
        step(v(0,0,0,1,0,20'h00412,0,8'h00, RF,4'b0001,4'h0, 1,8'hA5));
        step(v(1,0,0,1,0,20'h00412,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));
        step(v(0,0,1,1,0,20'h00412,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));

        // Reset coinciding with the DATA cycle of a write: no commit.
        step(v(0,1,1,1,0,20'h00412,0,8'h00, RF,4'b0001,4'h0, 1,8'hFF));
        step(v(0,0,1,0,0,20'h00412,1,8'h99, RF,4'b0001,4'h0, 0,8'h00));
        step(v(1,0,1,0,0,20'h00412,1,8'h99, RF,4'h0,4'h0, 0,8'h00));
        step(v(0,0,1,1,0,20'h00412,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));
        step(v(0,1,1,1,0,20'h00412,0,8'h00, RF,4'b0001,4'h0, 1,8'hFF));
        step(v(0,0,0,1,0,20'h00412,0,8'h00, RF,4'b0001,4'h0, 1,8'hA5));
        step(v(0,0,1,1,0,20'h00412,0,8'h00, RF,4'b0001,4'h0, 1,8'hFF));
        step(v(0,0,1,1,0,20'h00412,0,8'h00, RF,4'h0,4'h0, 1,8'hFF));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
